// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encoding for the UART transmitter.
//   UART_N_DEF             default data bits per frame
//   UART_CLKS_PER_BIT_DEF  default clk cycles per bit (100 MHz / 115200 baud)
//   uart_state_e           FSM encoding; ST_PARITY exists only with UART_TX_PARITY_EN
package uart_pkg;

  localparam int UART_N_DEF            = 8;
  localparam int UART_CLKS_PER_BIT_DEF = 868;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer for the UART transmitter.
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   clear  force the counter to 0 (frame accept)
//   run    count while a frame is in flight
//   tick   high on the last cycle of each bit period; counter wraps to 0 with it
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = run && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clear || tick) cnt_d = '0;
    else if (run)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter (start, N data bits LSB first, stop).
//   clk     system clock, rising edge
//   reset   asynchronous, active-low
//   enable  upstream request; a byte is taken on an edge with enable=1 in IDLE
//   bus     N-bit data, latched at accept and ignored afterwards
//   busy    registered, high from accept edge to the end of the stop bit
//   tx      registered serial line, idle high
//   done    registered one-cycle pulse when the stop bit completes
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int N            = UART_N_DEF,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] bus,
  output logic         busy,
  output logic         tx,
  output logic         done
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  uart_state_e   state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef UART_TX_PARITY_EN
  // Parity is taken at accept because the shift register is consumed by DATA.
  logic          par_q, par_d;
`endif

  logic accept, run, tick;

  assign accept = (state_q == ST_IDLE) && enable;
  assign run    = (state_q != ST_IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .run   (run),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_START;
          shift_d   = bus;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d     = ^bus;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign busy = busy_q;
  assign tx   = tx_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (N=8, CLKS_PER_BIT=4).
// A frame-level model (cycles since accept -> bit index -> expected level)
// is compared against tx/busy/done on every falling edge, and a line decoder
// recovers bytes from tx for literal checks of the directed cases.
module tb_uart_tx;

  localparam int N = 8;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = N + 3;
  localparam bit PAR = 1'b1;
  localparam int EXP_BUSY = 44;
`else
  localparam int NB = N + 2;
  localparam bit PAR = 1'b0;
  localparam int EXP_BUSY = 40;
`endif
  localparam int FLEN = NB * C;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] bus = '0;
  logic         busy, tx, done;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(.N(N), .CLKS_PER_BIT(C)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus),
    .busy   (busy),
    .tx     (tx),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Level of bit slot idx of a frame carrying b.
  function automatic logic exp_bit(input logic [N-1:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= N) return b[idx-1];
    if (PAR && idx == N + 1) return ^b;
    return 1'b1;
  endfunction

  // ---------------- frame-level model ----------------
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  int           m_k    = 0;
  logic [N-1:0] m_byte = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_k    = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_k++;
        if (m_k == FLEN) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (enable) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_byte = bus;
      end
    end
  end

  // ---------------- line decoder ----------------
  logic [N-1:0] rxq[$];
  logic [N-1:0] rx_log[$];
  bit           s_act = 1'b0;
  int           s_j   = 0;
  logic [N-1:0] s_byte = '0;

  always @(negedge clk) begin
    int b;
    if (!reset) begin
      s_act = 1'b0;
      rxq.delete();
    end else if (s_act) begin
      if (s_j % C == C / 2) begin
        b = s_j / C;
        if (b >= 1 && b <= N) s_byte[b-1] = tx;
        else if (b == NB - 1) begin
          check("rx_stop_bit", tx, 1'b1);
          rxq.push_back(s_byte);
          rx_log.push_back(s_byte);
          s_act = 1'b0;
        end
`ifdef UART_TX_PARITY_EN
        else if (b == N + 1) check("rx_parity_bit", tx, ^s_byte);
`endif
      end
      s_j++;
    end else if (tx === 1'b0) begin
      s_act = 1'b1;
      s_j   = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("tx", tx, m_busy ? exp_bit(m_byte, m_k / C) : 1'b1);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    if (m_done) begin
      if (rxq.size() == 0) check("rx_frame_present", 0, 1);
      else                 check("rx_byte", rxq.pop_front(), m_byte);
    end
  end

  // ---------------- stimulus ----------------
  bit pat [NB];

  initial begin
    int bad, nbusy, ndone, cnt;
    bit ok;
`ifdef UART_TX_PARITY_EN
    pat = '{0, 1, 1, 1, 0, 1, 0, 1, 0, 1, 1};
`else
    pat = '{0, 1, 1, 1, 0, 1, 0, 1, 0, 1};
`endif

    // Reset state
    @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // Idle with enable low for 100 cycles
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_100_violations", bad, 0);

    // Single frame 0x57 against a literal waveform
    rx_log.delete();
    enable = 1'b1; bus = 8'h57;
    @(negedge clk);
    enable = 1'b0;
    nbusy = 0; ndone = 0; bad = 0;
    for (int j = 0; j < FLEN + 4; j++) begin
      if (j > 0) @(negedge clk);
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) ndone++;
      if (j < FLEN && tx !== pat[j / C]) bad++;
    end
    check("w_waveform_errors", bad, 0);
    check("w_busy_cycles", nbusy, EXP_BUSY);
    check("w_done_pulses", ndone, 1);
    check("w_rx_count", rx_log.size(), 1);
    if (rx_log.size() > 0) check("w_rx_byte", rx_log[0], 8'h57);

    // Back-to-back with enable held: 0x57 then 0x61
    rx_log.delete();
    enable = 1'b1; bus = 8'h57;
    @(negedge clk);
    ok = 1'b0;
    for (int j = 0; j < FLEN + 5; j++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) check("b2b_first_end_timeout", 0, 1);
    bus = 8'h61;
    cnt = 1; bad = (tx !== 1'b1) ? 1 : 0;
    ok = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (busy === 1'b1) begin ok = 1'b1; break; end
      cnt++;
      if (tx !== 1'b1) bad++;
    end
    if (!ok) check("b2b_second_start_timeout", 0, 1);
    enable = 1'b0;
    check("b2b_idle_cycles", cnt, 1);
    check("b2b_idle_tx_low", bad, 0);
    ok = 1'b0;
    for (int j = 0; j < FLEN + 5; j++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) check("b2b_second_end_timeout", 0, 1);
    repeat (3) @(negedge clk);
    check("b2b_rx_count", rx_log.size(), 2);
    if (rx_log.size() > 1) begin
      check("b2b_rx0", rx_log[0], 8'h57);
      check("b2b_rx1", rx_log[1], 8'h61);
    end

    // Bus change mid-frame does not alter the frame
    rx_log.delete();
    enable = 1'b1; bus = 8'h57;
    @(negedge clk);
    enable = 1'b0;
    repeat (9) @(negedge clk);
    bus = 8'hFF;
    repeat (FLEN) @(negedge clk);
    check("bus_change_rx_count", rx_log.size(), 1);
    if (rx_log.size() > 0) check("bus_change_rx_byte", rx_log[0], 8'h57);

    // Reset mid-frame acts without a clock edge
    rx_log.delete();
    enable = 1'b1; bus = 8'h57;
    @(negedge clk);
    enable = 1'b0;
    repeat (16) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_rst_idle_violations", bad, 0);
    check("post_rst_rx_count", rx_log.size(), 0);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 3) != 0);
      bus    = N'($urandom);
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
      end
    end
    @(negedge clk);
    enable = 1'b0;
    repeat (FLEN + 5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
